// File: rtl/latch_write_arbiter.sv
// -----------------------------------------------------------------------------
// latch_write_arbiter
//   Arbitrates four requesters onto one shared N-bit level-sensitive latch.
//   A grant runs a fixed sequence: SETUP (data stable, enable low), EN
//   (enable high for EN_CYC cycles), HOLD (enable low, data still stable),
//   then ACK (one-cycle pulse to the winner).
//   Grants are round-robin, starting after the last winner.
//
// Ports
//   clk_in        : clock, rising edge
//   rst_in        : asynchronous active-high reset
//   req_in[3:0]   : per-requester write request (sampled only in IDLE)
//   data_in[4N-1:0]: requester i data at [i*N +: N]
//   ack_out[3:0]  : one-cycle completion pulse to the granted requester
//   lat_en_out    : enable of the shared latch
//   lat_d_out[N-1:0]: data to the shared latch
//   owner_out[1:0]: requester whose data was last written
//   owner_vld_out : at least one write completed since reset
//   busy_out      : a transaction is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module latch_write_arbiter #(
  parameter int N      = 8,
  parameter int EN_CYC = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [3:0]     req_in,
  input  logic [4*N-1:0] data_in,
  output logic [3:0]     ack_out,
  output logic           lat_en_out,
  output logic [N-1:0]   lat_d_out,
  output logic [1:0]     owner_out,
  output logic           owner_vld_out,
  output logic           busy_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN    = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  localparam logic [3:0] EN_LAST = 4'(EN_CYC - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lat_en_q, lat_en_d;
  logic [3:0] ack_q, ack_d;

  logic [1:0]   ptr_q, win_q, owner_q;
  logic         owner_vld_q;
  logic [N-1:0] lat_d_q;

  logic [3:0][N-1:0] data_arr;
  logic [1:0]        pick;
  logic              pick_vld;

  assign data_arr = data_in;

  // Round-robin search ptr+1 .. ptr+4 (mod 4). Walking from the far end
  // down lets the nearest set bit overwrite the others.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req_in[ptr_q + 2'(k)]) begin
        pick     = ptr_q + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  // State register. Enable and ack are flops so the latch and the
  // requesters only ever see clean, registered levels.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lat_en_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_EN;
        cnt_d   = '0;
      end
      S_EN: begin
        if (cnt_q == EN_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    lat_en_d = (state_d == S_EN);
    ack_d    = (state_d == S_ACK) ? (4'b0001 << win_q) : 4'b0000;
  end

  // Datapath: winner and data captured at the grant edge, bookkeeping
  // updated at the ACK exit edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q       <= 2'd3;
      win_q       <= '0;
      lat_d_q     <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && pick_vld) begin
        win_q   <= pick;
        lat_d_q <= data_arr[pick];
      end
      if (state_q == S_ACK) begin
        ptr_q       <= win_q;
        owner_q     <= win_q;
        owner_vld_q <= 1'b1;
      end
    end
  end

  assign ack_out       = ack_q;
  assign lat_en_out    = lat_en_q;
  assign lat_d_out     = lat_d_q;
  assign owner_out     = owner_q;
  assign owner_vld_out = owner_vld_q;
  assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
module tb_latch_write_arbiter;

  localparam int EA = 2;  // EN_CYC of dut_a
  localparam int EB = 1;  // EN_CYC of dut_b

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_a = '0, ack_a;
  logic [31:0] data_a = '0;
  logic        en_a, vld_a, busy_a;
  logic [7:0]  d_a;
  logic [1:0]  own_a;

  logic [3:0]  req_b = '0, ack_b;
  logic [31:0] data_b = '0;
  logic        en_b, vld_b, busy_b;
  logic [7:0]  d_b;
  logic [1:0]  own_b;

  latch_write_arbiter #(.N(8), .EN_CYC(EA)) dut_a (
    .clk_in(clk), .rst_in(rst), .req_in(req_a), .data_in(data_a),
    .ack_out(ack_a), .lat_en_out(en_a), .lat_d_out(d_a),
    .owner_out(own_a), .owner_vld_out(vld_a), .busy_out(busy_a));

  latch_write_arbiter #(.N(8), .EN_CYC(EB)) dut_b (
    .clk_in(clk), .rst_in(rst), .req_in(req_b), .data_in(data_b),
    .ack_out(ack_b), .lat_en_out(en_b), .lat_d_out(d_b),
    .owner_out(own_b), .owner_vld_out(vld_b), .busy_out(busy_b));

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural image of the external latch driven by dut_a
  logic [7:0] latch_a = '0;
  always @(en_a or d_a) if (en_a) latch_a = d_a;

  // Reference model state: last winner per DUT (3 after reset)
  int ptr_a = 3, ptr_b = 3;

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_a = 3; ptr_b = 3;
  endtask

  task automatic test_reset();
    #3;  // before the first clock edge: reset alone must define outputs
    chk_cnt++; if (en_a !== 1'b0)   $display("FAIL rst_en_a got %b want 0", en_a); else pass_cnt++;
    chk_cnt++; if (d_a !== 8'h00)   $display("FAIL rst_d_a got %h want 00", d_a); else pass_cnt++;
    chk_cnt++; if (ack_a !== 4'h0)  $display("FAIL rst_ack_a got %b want 0000", ack_a); else pass_cnt++;
    chk_cnt++; if (own_a !== 2'd0)  $display("FAIL rst_own_a got %0d want 0", own_a); else pass_cnt++;
    chk_cnt++; if (vld_a !== 1'b0)  $display("FAIL rst_vld_a got %b want 0", vld_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("FAIL rst_busy_a got %b want 0", busy_a); else pass_cnt++;
    chk_cnt++; if (en_b !== 1'b0 || ack_b !== 4'h0 || vld_b !== 1'b0)
      $display("FAIL rst_b got en=%b ack=%b vld=%b want 0", en_b, ack_b, vld_b); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_a = 3; ptr_b = 3;
  endtask

  task automatic test_single();
    int w;
    logic [3:0] ea;
    req_a  = 4'b0001;
    data_a = {$urandom_range(0, 32'hFFFFFF)} << 8 | 32'hA5;
    w = rr_pick(ptr_a, req_a);
    for (int k = 0; k <= EA + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_a = '0;
      ea = (k == EA + 2) ? 4'(1 << w) : 4'h0;
      chk_cnt++; if (en_a !== (k >= 1 && k <= EA)) $display("FAIL single_en k=%0d got %b", k, en_a); else pass_cnt++;
      chk_cnt++; if (ack_a !== ea) $display("FAIL single_ack k=%0d got %b want %b", k, ack_a, ea); else pass_cnt++;
      chk_cnt++; if (d_a !== 8'hA5) $display("FAIL single_d k=%0d got %h want a5", k, d_a); else pass_cnt++;
      chk_cnt++; if (busy_a !== (k <= EA + 2)) $display("FAIL single_busy k=%0d got %b", k, busy_a); else pass_cnt++;
    end
    ptr_a = w;
    chk_cnt++; if (own_a !== 2'(w) || vld_a !== 1'b1)
      $display("FAIL single_owner got %0d/%b want %0d/1", own_a, vld_a, w); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    int last_ack = -1;
    logic [3:0] ea;
    do_reset();
    req_a  = 4'hF;
    data_a = $urandom;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k <= 5; k++) begin
        @(posedge clk); #1;
        if (k == 0) req_a = 4'hF;
        ea = (k == 4) ? 4'(1 << order[t]) : 4'h0;
        chk_cnt++; if (ack_a !== ea) $display("FAIL fair_ack t=%0d k=%0d got %b want %b", t, k, ack_a, ea); else pass_cnt++;
        if (ack_a != 4'h0) begin
          if (last_ack >= 0) begin
            chk_cnt++; if (cyc - last_ack !== 6) $display("FAIL fair_gap got %0d want 6", cyc - last_ack); else pass_cnt++;
          end
          last_ack = cyc;
        end
        if (k == 5) begin
          chk_cnt++; if (own_a !== 2'(order[t])) $display("FAIL fair_owner got %0d want %0d", own_a, order[t]); else pass_cnt++;
          req_a[order[t]] = 1'b0;
          if (t == 4) req_a = '0;
        end
      end
    end
    ptr_a = order[4];
  endtask

  task automatic test_data_stability();
    logic [3:0] ea;
    req_a   = 4'b0100;
    data_a  = $urandom;
    data_a[23:16] = 8'h3C;
    latch_a = 8'h00;
    for (int k = 0; k <= EA + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_a = '0;
      ea = (k == EA + 2) ? 4'b0100 : 4'h0;
      chk_cnt++; if (d_a !== 8'h3C) $display("FAIL stab_d k=%0d got %h want 3c", k, d_a); else pass_cnt++;
      chk_cnt++; if (ack_a !== ea) $display("FAIL stab_ack k=%0d got %b want %b", k, ack_a, ea); else pass_cnt++;
      if (k == 1) data_a[23:16] = 8'hFF;
    end
    chk_cnt++; if (latch_a !== 8'h3C) $display("FAIL stab_latch got %h want 3c", latch_a); else pass_cnt++;
    ptr_a = 2;
  endtask

  task automatic test_mid_drop();
    logic [3:0] ea;
    req_a  = 4'b0010;
    data_a = $urandom;
    for (int k = 0; k <= EA + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_a = '0;
      ea = (k == EA + 2) ? 4'b0010 : 4'h0;
      chk_cnt++; if (ack_a !== ea) $display("FAIL drop_ack k=%0d got %b want %b", k, ack_a, ea); else pass_cnt++;
      chk_cnt++; if (en_a !== (k >= 1 && k <= EA)) $display("FAIL drop_en k=%0d got %b", k, en_a); else pass_cnt++;
    end
    chk_cnt++; if (own_a !== 2'd1) $display("FAIL drop_owner got %0d want 1", own_a); else pass_cnt++;
    ptr_a = 1;
  endtask

  task automatic test_reset_mid_en();
    int w;
    logic [3:0] ea;
    req_a  = 4'b0110;
    data_a = $urandom;
    @(posedge clk); #1;  // SETUP
    @(posedge clk); #1;  // EN
    chk_cnt++; if (en_a !== 1'b1) $display("FAIL rmid_pre_en got %b want 1", en_a); else pass_cnt++;
    #2 rst = 1'b1;
    #1;  // still well before the next clock edge
    chk_cnt++; if (en_a !== 1'b0) $display("FAIL rmid_en got %b want 0", en_a); else pass_cnt++;
    chk_cnt++; if (ack_a !== 4'h0) $display("FAIL rmid_ack got %b want 0000", ack_a); else pass_cnt++;
    chk_cnt++; if (vld_a !== 1'b0) $display("FAIL rmid_vld got %b want 0", vld_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy_a); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_a = 3; ptr_b = 3;
    w = rr_pick(ptr_a, req_a);
    for (int k = 0; k <= EA + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_a = '0;
      ea = (k == EA + 2) ? 4'(1 << w) : 4'h0;
      chk_cnt++; if (ack_a !== ea) $display("FAIL rmid_regrant k=%0d got %b want %b", k, ack_a, ea); else pass_cnt++;
    end
    ptr_a = w;
  endtask

  task automatic test_min_en();
    logic [3:0] ea;
    req_b  = 4'b1000;
    data_b = $urandom;
    for (int k = 0; k <= EB + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_b = '0;
      ea = (k == EB + 2) ? 4'b1000 : 4'h0;
      chk_cnt++; if (en_b !== (k == 1)) $display("FAIL minen_en k=%0d got %b", k, en_b); else pass_cnt++;
      chk_cnt++; if (ack_b !== ea) $display("FAIL minen_ack k=%0d got %b want %b", k, ack_b, ea); else pass_cnt++;
      chk_cnt++; if (d_b !== data_b[31:24]) $display("FAIL minen_d k=%0d got %h want %h", k, d_b, data_b[31:24]); else pass_cnt++;
    end
    chk_cnt++; if (own_b !== 2'd3 || vld_b !== 1'b1)
      $display("FAIL minen_owner got %0d/%b want 3/1", own_b, vld_b); else pass_cnt++;
    ptr_b = 3;
  endtask

  task automatic test_random();
    int w;
    logic [3:0] ea;
    logic [7:0] ed;
    for (int t = 0; t < 24; t++) begin
      req_a  = 4'($urandom_range(1, 15));
      data_a = $urandom;
      w  = rr_pick(ptr_a, req_a);
      ed = data_a[8*w +: 8];
      for (int k = 0; k <= EA + 3; k++) begin
        @(posedge clk); #1;
        ea = (k == EA + 2) ? 4'(1 << w) : 4'h0;
        chk_cnt++; if (en_a !== (k >= 1 && k <= EA)) $display("FAIL rand_en t=%0d k=%0d got %b", t, k, en_a); else pass_cnt++;
        chk_cnt++; if (ack_a !== ea) $display("FAIL rand_ack t=%0d k=%0d got %b want %b", t, k, ack_a, ea); else pass_cnt++;
        chk_cnt++; if (d_a !== ed) $display("FAIL rand_d t=%0d k=%0d got %h want %h", t, k, d_a, ed); else pass_cnt++;
        chk_cnt++; if (busy_a !== (k <= EA + 2)) $display("FAIL rand_busy t=%0d k=%0d got %b", t, k, busy_a); else pass_cnt++;
        // Noise on requests and data while not in IDLE must be ignored
        if (k <= EA + 1) begin
          req_a  = 4'($urandom);
          data_a = $urandom;
        end else if (k == EA + 2) begin
          req_a = '0;
        end
      end
      ptr_a = w;
      chk_cnt++; if (own_a !== 2'(w) || vld_a !== 1'b1)
        $display("FAIL rand_owner t=%0d got %0d/%b want %0d/1", t, own_a, vld_a, w); else pass_cnt++;
    end
    req_a = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_data_stability();
    test_mid_drop();
    test_reset_mid_en();
    test_min_en();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 Parameter N, default 8: data width of the shared latch; legal range 1 or more.
REQ-002 Parameter EN_CYC, default 2: width of the latch-enable pulse in clock cycles; legal range 1 to 15.
REQ-003 clk_in, input, 1: single clock; all state updates on rising edge.
REQ-004 rst_in, input, 1: reset; asynchronous, active-high.
REQ-005 req_in, input, 4: per-requester write request; bit i belongs to requester i.
REQ-006 data_in, input, 4*N: requester i data at bits [i*N+N-1 : i*N].
REQ-007 ack_out, input-side handshake output, 4: one-cycle completion pulse to the granted requester.
REQ-008 lat_en_out, output, 1: enable to the shared N-bit level-sensitive latch.
REQ-009 lat_d_out, output, N: data to the shared latch.
REQ-010 owner_out, output, 2: index of the requester whose data was last written.
REQ-011 owner_vld_out, output, 1: high once at least one write has completed since reset.
REQ-012 busy_out, output, 1: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, SETUP, EN, HOLD and ACK, all registered.
REQ-014 In IDLE with req_in nonzero, the block SHALL grant one requester by round-robin: search ptr+1, ptr+2, ptr+3, ptr+4 (mod 4), and take the first set bit.
REQ-015 At the grant edge, the block SHALL register the winner index and the winner's data_in slice into lat_d_out, then enter SETUP.
REQ-016 In IDLE with req_in zero, the block SHALL stay in IDLE, with lat_en_out low and lat_d_out unchanged.
REQ-017 SETUP SHALL last 1 cycle with lat_en_out low (data setup), then move to EN.
REQ-018 EN SHALL last exactly EN_CYC cycles with lat_en_out high, counted by an internal 4-bit counter, then move to HOLD.
REQ-019 HOLD SHALL last 1 cycle with lat_en_out low (data hold), then move to ACK.
REQ-020 ACK SHALL last 1 cycle, with the following actions:
- ack_out[winner] high, all other ack_out bits low;
- ptr, owner_out and owner_vld_out updated at the exit edge;
- then return to IDLE.
REQ-021 lat_d_out SHALL remain constant from the SETUP entry through the ACK exit; changes to data_in after the grant SHALL be ignored.
REQ-022 lat_en_out and ack_out SHALL be driven directly from registered state (glitch-free).
REQ-023 Latency SHALL be fixed: a request sampled in IDLE at cycle t produces ack_out at cycle t+3+EN_CYC (t+5 for the default).
REQ-024 req_in SHALL be sampled only in IDLE; requests raised or dropped during SETUP, EN, HOLD or ACK SHALL NOT alter the current transaction.
REQ-025 If the granted requester deasserts req_in mid-transaction, the write SHALL still complete and be acknowledged.
REQ-026 Each requester SHALL drop req_in on the cycle after its ack_out; a req_in still high in IDLE SHALL be treated as a new request.
REQ-027 With all four requesters continuously active, grants SHALL rotate 0,1,2,3,0, and no requester SHALL wait more than 3 transactions.
REQ-028 At most one ack_out bit SHALL be high in any cycle, and lat_en_out SHALL never be high in IDLE or ACK.

Reset
REQ-029 While rst_in is high, the block SHALL immediately force the following, independent of clk_in:
- state IDLE;
- lat_en_out 0, lat_d_out 0, ack_out 0;
- owner_out 0, owner_vld_out 0, busy_out 0;
- ptr 3, so requester 0 has first priority;
- EN counter 0.
REQ-030 A reset asserted mid-transaction SHALL abort it:
- lat_en_out drops asynchronously;
- no ack_out is issued;
- the aborted requester SHALL re-request after reset.
REQ-031 After reset deassertion, the first grant SHALL occur on the first rising edge at which req_in is nonzero in IDLE.

Verification
REQ-032 The bench SHALL cover single request: req_in=0001, data_in[7:0]=0xA5, EN_CYC=2 -> the following response:
- lat_en_out high for cycles t+2 and t+3;
- lat_d_out=0xA5 from t+1;
- ack_out=0001 at t+5;
- owner_out=0 and owner_vld_out=1 after the ack.
REQ-033 The bench SHALL cover fairness: req_in=1111 held, each requester dropping its request for one cycle after its ack -> ack order 0,1,2,3,0, one ack every 6 cycles.
REQ-034 The bench SHALL cover data stability: requester 2 granted with data 0x3C, then data_in[23:16] changed to 0xFF during EN -> lat_d_out stays 0x3C, the latch captures 0x3C, and ack_out=0100.
REQ-035 The bench SHALL cover a mid-transaction drop: requester 1 drops req_in during EN -> the write completes and ack_out=0010 is issued at the normal cycle.
REQ-036 The bench SHALL cover reset mid-EN: rst_in pulsed while lat_en_out=1 -> lat_en_out=0 before the next clock edge, no ack, owner_vld_out=0, and the next grant goes to the lowest set req_in bit.
REQ-037 The bench SHALL cover the minimum enable width: EN_CYC=1 with req_in=1000 -> lat_en_out high for exactly 1 cycle and ack_out=1000 at t+4.
